// File: rtl/icache_pkg.sv
// Shared types, constants and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_REFILL    = 2'd1;
    localparam state_t ST_FILL_DONE = 2'd2;

    localparam logic [31:0] ICACHE_NOP = 32'h00000013;

    // Generic bitfield extractor; callers narrow the result to the field width.
    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return (addr >> lsb) & mask;
    endfunction

    function automatic logic [63:0] addr_offset(input logic [63:0] addr, input int off_w);
        return addr_field(addr, 2, off_w);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int off_w, input int idx_w);
        return addr_field(addr, 2 + off_w, idx_w);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int off_w, input int idx_w,
                                             input int addr_w);
        return addr_field(addr, 2 + off_w + idx_w, addr_w - 2 - off_w - idx_w);
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Miss handling: latches the missing line, runs the word-per-beat req/ack refill and
// strobes data/tag/valid writes into the cache arrays.
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss,
    input  logic                         flush,
    input  logic [ADDR_WIDTH-1:0]        line_base,
    input  logic                         mem_ack,
    output logic                         mem_req,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output state_t                       state,
    output logic [ADDR_WIDTH-1:0]        miss_addr,
    output logic [$clog2(LINE_WORDS)-1:0] wr_word,
    output logic                         data_we,
    output logic                         fill_en,
    output logic                         fill_valid
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    state_t                  state_q, state_d;
    logic [OFF_W-1:0]        beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]   miss_addr_q, miss_addr_d;
    logic                    drop_q, drop_d;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        miss_addr_d = miss_addr_q;
        drop_d      = drop_q;
        case (state_q)
            ST_IDLE: begin
                // A miss coinciding with a flush is left to re-miss on the next cycle.
                if (miss && !flush) begin
                    miss_addr_d = line_base;
                    beat_d      = '0;
                    drop_d      = 1'b0;
                    state_d     = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (flush) drop_d = 1'b1;
                if (mem_ack) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = ST_FILL_DONE;
                end
            end
            ST_FILL_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            miss_addr_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            miss_addr_q <= miss_addr_d;
            drop_q      <= drop_d;
        end
    end

    assign mem_req    = (state_q == ST_REFILL);
    assign mem_addr   = mem_req ? (miss_addr_q + ADDR_WIDTH'({beat_q, 2'b00})) : '0;
    assign state      = state_q;
    assign miss_addr  = miss_addr_q;
    assign wr_word    = beat_q;
    assign data_we    = mem_req && mem_ack;
    assign fill_en    = (state_q == ST_FILL_DONE);
    assign fill_valid = fill_en && !drop_q;

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path in front of fetch,
// stalls fetch while icache_refill_fsm refills a missing line.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          LINE_WORDS = 4,
    parameter int          NUM_LINES  = 16,
    parameter logic [31:0] NOP_INSTR  = ICACHE_NOP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] PCF,
    input  logic                  FlushF,
    output logic [31:0]           InstrF,
    output logic                  StallF,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;

    logic [31:0]           data_q [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid_q, valid_d;

    logic [OFF_W-1:0]      pc_off;
    logic [IDX_W-1:0]      pc_idx, miss_idx;
    logic [TAG_W-1:0]      pc_tag, miss_tag;
    logic [ADDR_WIDTH-1:0] line_base, miss_addr;
    state_t                state;
    logic [OFF_W-1:0]      wr_word;
    logic                  data_we, fill_en, fill_valid;
    logic                  lookup_hit;

    assign pc_off    = OFF_W'(addr_offset(64'(PCF), OFF_W));
    assign pc_idx    = IDX_W'(addr_index(64'(PCF), OFF_W, IDX_W));
    assign pc_tag    = TAG_W'(addr_tag(64'(PCF), OFF_W, IDX_W, ADDR_WIDTH));
    assign miss_idx  = IDX_W'(addr_index(64'(miss_addr), OFF_W, IDX_W));
    assign miss_tag  = TAG_W'(addr_tag(64'(miss_addr), OFF_W, IDX_W, ADDR_WIDTH));
    assign line_base = PCF & ~ADDR_WIDTH'(LINE_WORDS * 4 - 1);

    // Lookup only in IDLE; during a refill fetch sees a NOP and a stall.
    assign lookup_hit = (state == ST_IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign InstrF     = lookup_hit ? data_q[pc_idx][pc_off] : NOP_INSTR;
    assign StallF     = rst && !lookup_hit;

    icache_refill_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_refill (
        .clk        (clk),
        .rst        (rst),
        .miss       (!lookup_hit),
        .flush      (FlushF),
        .line_base  (line_base),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .state      (state),
        .miss_addr  (miss_addr),
        .wr_word    (wr_word),
        .data_we    (data_we),
        .fill_en    (fill_en),
        .fill_valid (fill_valid)
    );

    always_ff @(posedge clk) begin
        if (data_we) data_q[miss_idx][wr_word] <= mem_rdata;
        if (fill_en) tag_q[miss_idx] <= miss_tag;
    end

    // Flush wins over a same-cycle validate so a flushed refill never becomes visible.
    always_comb begin
        valid_d = valid_q;
        if (FlushF) begin
            valid_d = '0;
        end else if (fill_valid) begin
            valid_d[miss_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: cold miss, hit, eviction, wait states, flush and reset.
module tb_instruction_cache;

    logic        clk;
    logic        rst;
    logic [31:0] PCF;
    logic        FlushF;
    logic [31:0] InstrF;
    logic        StallF;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          wait_cfg     = 0;
    int          wait_cnt     = 0;
    logic [31:0] beat_log[$];
    logic        pend_q       = 1'b0;
    logic [31:0] pend_addr    = '0;

    instruction_cache dut (
        .clk       (clk),
        .rst       (rst),
        .PCF       (PCF),
        .FlushF    (FlushF),
        .InstrF    (InstrF),
        .StallF    (StallF),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: word at byte address a holds 0xA0 + a/4; ack after wait_cfg idle cycles.
    always_comb begin
        mem_ack   = mem_req && (wait_cnt >= wait_cfg);
        mem_rdata = mem_ack ? (32'hA0 + (mem_addr >> 2)) : 32'hDEADBEEF;
    end

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Beat logger plus request/address hold check while a beat is waiting for its ack.
    always @(negedge clk) begin
        if (rst && pend_q) begin
            check("req_hold", {31'd0, mem_req}, 32'd1);
            check("addr_hold", mem_addr, pend_addr);
        end
        if (rst && mem_req && mem_ack) beat_log.push_back(mem_addr);
        pend_q    = rst && mem_req && !mem_ack;
        pend_addr = mem_addr;
    end

    task automatic wait_hit(output int stalls);
        stalls = 0;
        while (StallF && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check("hit_timeout", {31'd0, StallF}, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] pc, input int exp_stalls, input logic [31:0] exp_instr);
        int stalls;
        @(negedge clk);
        beat_log.delete();
        PCF = pc;
        #1;
        wait_hit(stalls);
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        check("instr", InstrF, exp_instr);
        $display("[TB] fetch pc=%h stalls=%0d instr=%h", pc, stalls, InstrF);
    endtask

    task automatic check_beats(input logic [31:0] base, input int n);
        check("beat_count", 32'(beat_log.size()), 32'(n));
        for (int i = 0; i < n && i < beat_log.size(); i++) begin
            check("beat_addr", beat_log[i], base + 32'(4 * (i % 4)));
        end
    endtask

    initial begin
        int stalls;
        rst    = 1'b1;
        PCF    = 32'h0;
        FlushF = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stall", {31'd0, StallF}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_instr", InstrF, 32'h00000013);

        // 1: cold miss straight out of reset
        beat_log.delete();
        rst = 1'b1;
        #1;
        wait_hit(stalls);
        check("cold_stalls", 32'(stalls), 32'd6);
        check("cold_instr", InstrF, 32'hA0);
        check_beats(32'h0, 4);
        $display("[TB] cold miss stalls=%0d instr=%h", stalls, InstrF);

        // 2: hit in the refilled line
        fetch(32'h8, 0, 32'hA2);
        check("hit_req", {31'd0, mem_req}, 32'd0);

        // 3: conflict eviction on index 0
        fetch(32'h100, 6, 32'hE0);
        check_beats(32'h100, 4);
        fetch(32'h0, 6, 32'hA0);
        check_beats(32'h0, 4);

        // 4: three wait states per beat
        wait_cfg = 3;
        fetch(32'h20, 18, 32'hA8);
        check_beats(32'h20, 4);
        wait_cfg = 0;

        // 5: flush during beat 1 -> line dropped, immediate re-miss refills again
        @(negedge clk);
        beat_log.delete();
        PCF = 32'h30;
        #1;
        check("f5_miss_stall", {31'd0, StallF}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("f5_beat1_addr", mem_addr, 32'h34);
        FlushF = 1'b1;
        @(negedge clk);
        FlushF = 1'b0;
        #1;
        wait_hit(stalls);
        check("f5_stalls", 32'(stalls), 32'd9);
        check("f5_instr", InstrF, 32'hAC);
        check_beats(32'h30, 8);
        $display("[TB] flush mid-refill stalls=%0d beats=%0d", stalls, beat_log.size());
        fetch(32'h0, 6, 32'hA0);

        // IDLE flush: same-cycle hit still served, next cycle misses
        @(negedge clk);
        PCF    = 32'h4;
        FlushF = 1'b1;
        #1;
        check("idle_flush_stall", {31'd0, StallF}, 32'd0);
        check("idle_flush_instr", InstrF, 32'hA1);
        @(negedge clk);
        FlushF = 1'b0;
        beat_log.delete();
        #1;
        wait_hit(stalls);
        check("post_flush_stalls", 32'(stalls), 32'd6);
        check("post_flush_instr", InstrF, 32'hA1);
        $display("[TB] idle flush re-miss stalls=%0d instr=%h", stalls, InstrF);

        // 6: async reset during beat 2
        @(negedge clk);
        PCF = 32'h40;
        #1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("r6_beat2_addr", mem_addr, 32'h48);
        rst = 1'b0;
        #1;
        check("r6_req", {31'd0, mem_req}, 32'd0);
        check("r6_stall", {31'd0, StallF}, 32'd0);
        check("r6_addr", mem_addr, 32'd0);
        @(negedge clk);
        beat_log.delete();
        PCF = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        wait_hit(stalls);
        check("r6_stalls", 32'(stalls), 32'd6);
        check("r6_instr", InstrF, 32'hA0);
        check_beats(32'h0, 4);
        $display("[TB] post-reset refill stalls=%0d instr=%h", stalls, InstrF);
        fetch(32'h40, 6, 32'hB0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
